oled_i2c_arbiter: RTL and testbench
===================================

Name: oled_i2c_arbiter

Overview:
- N-channel arbiter that multiplexes several OLED command sources (init sequencer, full-screen display pattern generator, dot-matrix text engine, future clients) onto the single write port of i2c_master.
- Successor to the fixed 3-way, state-selected mux in the OLED controller.
- Adds a parametrised channel count, round-robin or fixed-priority arbitration, burst ownership, a registered single-transaction handshake, and a watchdog on i2c_done.

Parameters:
- NUM_CH, 4, number of client channels (2..8).
- ADDR_W, 8, register-address width.
- DATA_W, 8, data width.
- RR_MODE, 1, 1 = round-robin starting after the last owner; 0 = fixed priority, ch0 highest.
- TIMEOUT_CYC, 50000, clk cycles to wait for i2c_done before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- ch_req  in  NUM_CH  per-channel level request; held high for the whole burst
- ch_gnt  out  NUM_CH  one-hot grant, registered
- ch_wen  in  NUM_CH  per-channel one-cycle write strobe; valid only while granted
- ch_addr  in  NUM_CH*ADDR_W  packed register addresses, ch0 in LSBs
- ch_data  in  NUM_CH*DATA_W  packed data, ch0 in LSBs
- ch_done  out  NUM_CH  one-cycle pulse to the owner when its transaction completes
- ch_timeout  out  NUM_CH  one-cycle pulse to the owner on watchdog abort
- i2c_reg_addr  out  ADDR_W  to i2c_master reg_addr, registered
- i2c_reg_data  out  DATA_W  to i2c_master data_in, registered
- i2c_write_en  out  1  one-cycle start pulse to i2c_master
- i2c_done  in  1  completion pulse from i2c_master
- busy  out  1  high whenever any channel is granted
- wen_overrun  out  1  one-cycle pulse when a strobe is dropped

Behaviour:
- Reset (asynchronous, active-low): state IDLE, rr_ptr=0, owner=0, all outputs 0 including i2c_reg_addr/data. Reset mid-transfer drops i2c_write_en and grant immediately; the pending i2c_done is not waited for.
- States: IDLE, GRANTED, XFER.
- IDLE:
  - If ch_req != 0, select the winner: RR_MODE=1 picks the first set bit scanning rr_ptr, rr_ptr+1, ... wrapping modulo NUM_CH; RR_MODE=0 picks the lowest set index.
  - Next cycle: ch_gnt[winner]=1, busy=1, state GRANTED. Request-to-grant latency is 1 cycle.
- GRANTED:
  - ch_wen[owner]=1: latch that channel's addr/data into i2c_reg_addr/data, pulse i2c_write_en on the following cycle (exactly 1 cycle wide), clear the watchdog counter, go to XFER.
  - ch_req[owner]=0 with no wen in the same cycle: drop grant, busy=0, rr_ptr=owner+1 (wrap), go to IDLE. A new grant can appear one cycle later at the earliest.
  - Simultaneous wen and req drop: the write is accepted, and release happens after completion.
- XFER:
  - Counter increments each cycle.
  - On i2c_done: pulse ch_done[owner] for 1 cycle. If ch_req[owner] is still high, return to GRANTED. Otherwise release (same as the GRANTED release path).
  - Watchdog (TIMEOUT_CYC != 0, counter reaches TIMEOUT_CYC-1 without i2c_done): pulse ch_timeout[owner], no ch_done, force release to IDLE, advance rr_ptr.
  - i2c_done and timeout in the same cycle: done wins.
- Any ch_wen while in XFER, or any ch_wen from a non-owner in any state: ignored, wen_overrun pulses 1 cycle. State and i2c outputs are unchanged.
- i2c_done arriving in IDLE/GRANTED: ignored, no ch_done.
- Grant is never changed mid-burst; no preemption, even by a higher-priority request.
- i2c_reg_addr/data hold the last latched values between transfers.
- Counter width is $clog2(TIMEOUT_CYC+1) and saturates.
- ch_done, ch_timeout and ch_gnt are always one-hot or zero.

Test Plan:
- Single burst: ch2 req, 3 wen strobes (addr 0x00, data 0xAE/0xD5/0x80), i2c_done 20 cycles after each i2c_write_en -> ch_gnt=4'b0100 one cycle after req, exactly 3 i2c_write_en pulses with matching addr/data, 3 ch_done[2] pulses, busy low one cycle after req drop.
- Round-robin fairness (RR_MODE=1): ch0 and ch3 request continuously, each releasing after 1 write -> grants alternate ch0, ch3, ch0, ch3. With RR_MODE=0 -> ch0 is re-granted every time.
- Watchdog: TIMEOUT_CYC=100, ch1 writes, i2c_done withheld -> ch_timeout[1] pulses exactly 100 cycles after the transfer starts, grant drops, no ch_done; pending ch3 request is granted next.
- Overrun: while ch0 is in XFER, ch0 wen and ch1 wen strobes -> two wen_overrun pulses, no extra i2c_write_en, latched addr/data unchanged.
- Boundary: i2c_done and ch_req[owner] fall in the same cycle -> one ch_done pulse, IDLE next cycle; i2c_done on the timeout cycle -> ch_done, no ch_timeout.
- Async reset asserted mid-XFER -> all outputs 0 without a clock edge; after release, ch1 req is granted with rr_ptr=0 ordering.

Source files
------------

// File: rtl/oled_i2c_arbiter.sv
// rtl/oled_i2c_arbiter.sv - N-channel arbiter feeding OLED command sources into the single i2c_master write port
// Grants are held for a whole burst; each accepted strobe becomes one registered i2c transaction.
module oled_i2c_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    output logic [NUM_CH-1:0]        ch_gnt,
    input  logic [NUM_CH-1:0]        ch_wen,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_timeout,
    output logic [ADDR_W-1:0]        i2c_reg_addr,
    output logic [DATA_W-1:0]        i2c_reg_data,
    output logic                     i2c_write_en,
    input  logic                     i2c_done,
    output logic                     busy,
    output logic                     wen_overrun
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);
    localparam logic [PTR_W:0]   NUM_CH_X = (PTR_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {IDLE, GRANTED, XFER} state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    owner, owner_nxt, rr_ptr, rr_ptr_nxt, winner, owner_inc;
    logic [PTR_W:0]      idx;
    logic                found;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [NUM_CH-1:0]   gnt_nxt, done_nxt, timeout_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                write_nxt, overrun_nxt, wd_fire;

    // Scan order starts at rr_ptr in round-robin mode, at ch0 otherwise.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (RR_MODE != 0) ? ({1'b0, rr_ptr} + (PTR_W + 1)'(i)) : (PTR_W + 1)'(i);
            if (idx >= NUM_CH_X) idx = idx - NUM_CH_X;
            if (!found && ch_req[idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    assign owner_inc = (owner == LAST_CH) ? '0 : owner + 1'b1;
    assign wd_fire   = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST) && !i2c_done;
    assign busy      = |ch_gnt;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        gnt_nxt     = ch_gnt;
        cnt_nxt     = cnt;
        addr_nxt    = i2c_reg_addr;
        data_nxt    = i2c_reg_data;
        write_nxt   = 1'b0;
        done_nxt    = '0;
        timeout_nxt = '0;
        // ch_gnt is zero in IDLE, so every strobe there counts as foreign.
        overrun_nxt = (state == XFER) ? |ch_wen : |(ch_wen & ~ch_gnt);
        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt       = winner;
                    gnt_nxt         = '0;
                    gnt_nxt[winner] = 1'b1;
                    state_nxt       = GRANTED;
                end
            end
            GRANTED: begin
                if (ch_wen[owner]) begin
                    addr_nxt  = ch_addr[owner*ADDR_W +: ADDR_W];
                    data_nxt  = ch_data[owner*DATA_W +: DATA_W];
                    write_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = XFER;
                end else if (!ch_req[owner]) begin
                    gnt_nxt    = '0;
                    rr_ptr_nxt = owner_inc;
                    state_nxt  = IDLE;
                end
            end
            XFER: begin
                if (i2c_done) begin
                    done_nxt = ch_gnt;
                    if (ch_req[owner]) begin
                        state_nxt = GRANTED;
                    end else begin
                        gnt_nxt    = '0;
                        rr_ptr_nxt = owner_inc;
                        state_nxt  = IDLE;
                    end
                end else if (wd_fire) begin
                    timeout_nxt = ch_gnt;
                    gnt_nxt     = '0;
                    rr_ptr_nxt  = owner_inc;
                    state_nxt   = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            cnt          <= '0;
            ch_gnt       <= '0;
            ch_done      <= '0;
            ch_timeout   <= '0;
            i2c_reg_addr <= '0;
            i2c_reg_data <= '0;
            i2c_write_en <= 1'b0;
            wen_overrun  <= 1'b0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            rr_ptr       <= rr_ptr_nxt;
            cnt          <= cnt_nxt;
            ch_gnt       <= gnt_nxt;
            ch_done      <= done_nxt;
            ch_timeout   <= timeout_nxt;
            i2c_reg_addr <= addr_nxt;
            i2c_reg_data <= data_nxt;
            i2c_write_en <= write_nxt;
            wen_overrun  <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_oled_i2c_arbiter.sv
// tb/tb_oled_i2c_arbiter.sv - self-checking bench for oled_i2c_arbiter (round-robin and fixed-priority instances)
`timescale 1ns/1ps
module tb_oled_i2c_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0, wen = '0;
    logic [31:0] addr = '0, data = '0;
    logic        done_in = 1'b0;
    logic [3:0]  gnt, ch_done, ch_to;
    logic [7:0]  waddr, wdata;
    logic        wr_o, busy, ovr;

    logic [3:0]  fp_req = '0, fp_wen = '0;
    logic        fp_done_in = 1'b0;
    logic [3:0]  fp_gnt, fp_ch_done, fp_ch_to;
    logic [7:0]  fp_waddr, fp_wdata;
    logic        fp_wr_o, fp_busy, fp_ovr;

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t exp_q[$];

    int pass_cnt = 0, total_cnt = 0;
    int wr_cnt = 0, done_cnt = 0, to_cnt = 0, ovr_cnt = 0;

    always #5 clk = ~clk;

    oled_i2c_arbiter #(.NUM_CH(4), .ADDR_W(8), .DATA_W(8), .RR_MODE(1), .TIMEOUT_CYC(100)) dut_rr (
        .clk(clk), .reset(reset), .ch_req(req), .ch_gnt(gnt), .ch_wen(wen),
        .ch_addr(addr), .ch_data(data), .ch_done(ch_done), .ch_timeout(ch_to),
        .i2c_reg_addr(waddr), .i2c_reg_data(wdata), .i2c_write_en(wr_o),
        .i2c_done(done_in), .busy(busy), .wen_overrun(ovr)
    );

    oled_i2c_arbiter #(.NUM_CH(4), .ADDR_W(8), .DATA_W(8), .RR_MODE(0), .TIMEOUT_CYC(100)) dut_fp (
        .clk(clk), .reset(reset), .ch_req(fp_req), .ch_gnt(fp_gnt), .ch_wen(fp_wen),
        .ch_addr(addr), .ch_data(data), .ch_done(fp_ch_done), .ch_timeout(fp_ch_to),
        .i2c_reg_addr(fp_waddr), .i2c_reg_data(fp_wdata), .i2c_write_en(fp_wr_o),
        .i2c_done(fp_done_in), .busy(fp_busy), .wen_overrun(fp_ovr)
    );

    // Write scoreboard and pulse counters for the round-robin instance.
    always @(negedge clk) begin
        if (reset) begin
            if (wr_o) begin
                wr_t e;
                wr_cnt++;
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected_write: got addr %h data %h, required no write", waddr, wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({waddr, wdata} !== {e.a, e.d})
                        $display("FAIL sb_write: got %h/%h required %h/%h", waddr, wdata, e.a, e.d);
                    else
                        pass_cnt++;
                end
            end
            done_cnt += $countones(ch_done);
            to_cnt   += $countones(ch_to);
            ovr_cnt  += int'(ovr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        req = '0; wen = '0; done_in = 1'b0;
        fp_req = '0; fp_wen = '0; fp_done_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic do_write(input int ch, input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wen = '0;
        wen[ch] = 1'b1;
        addr[ch*8 +: 8] = a;
        data[ch*8 +: 8] = d;
        exp_q.push_back(e);
        tick();
        wen = '0;
    endtask

    task automatic pulse_done;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        total_cnt++;
        if ({gnt, ch_done, ch_to, waddr, wdata, wr_o, busy, ovr} !== '0)
            $display("FAIL reset_rr: got %b required all zero", {gnt, ch_done, ch_to, waddr, wdata, wr_o, busy, ovr});
        else pass_cnt++;
        total_cnt++;
        if ({fp_gnt, fp_ch_done, fp_ch_to, fp_waddr, fp_wdata, fp_wr_o, fp_busy, fp_ovr} !== '0)
            $display("FAIL reset_fp: got %b required all zero", {fp_gnt, fp_ch_done, fp_ch_to, fp_waddr, fp_wdata, fp_wr_o, fp_busy, fp_ovr});
        else pass_cnt++;
    endtask

    task automatic test_single_burst;
        logic [7:0] dv [3];
        int w0, d0;
        dv[0] = 8'hAE; dv[1] = 8'hD5; dv[2] = 8'h80;
        apply_reset();
        w0 = wr_cnt; d0 = done_cnt;
        req = 4'b0100;
        tick();
        total_cnt++;
        if (gnt !== 4'b0100 || busy !== 1'b1) $display("FAIL burst_grant: got gnt %b busy %b required 0100 1", gnt, busy);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            do_write(2, 8'h00, dv[k]);
            repeat (20) tick();
            pulse_done();
            total_cnt++;
            if (ch_done !== 4'b0100 || gnt !== 4'b0100) $display("FAIL burst_done%0d: got done %b gnt %b required 0100 0100", k, ch_done, gnt);
            else pass_cnt++;
        end
        req = '0;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || gnt !== 4'b0000) $display("FAIL burst_release: got busy %b gnt %b required 0 0000", busy, gnt);
        else pass_cnt++;
        total_cnt++;
        if (wr_cnt - w0 != 3 || done_cnt - d0 != 3) $display("FAIL burst_counts: got writes %0d dones %0d required 3 3", wr_cnt - w0, done_cnt - d0);
        else pass_cnt++;
        total_cnt++;
        if (waddr !== 8'h00 || wdata !== 8'h80) $display("FAIL burst_hold: got %h/%h required 00/80", waddr, wdata);
        else pass_cnt++;
    endtask

    task automatic test_rr_fairness;
        logic [3:0] exp;
        int ch, d0;
        apply_reset();
        d0 = done_cnt;
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 1) ? 4'b1000 : 4'b0001;
            ch  = (i % 2 == 1) ? 3 : 0;
            tick();
            total_cnt++;
            if (gnt !== exp) $display("FAIL rr_grant%0d: got %b required %b", i, gnt, exp);
            else pass_cnt++;
            do_write(ch, 8'(8'h40 + i), 8'(8'h10 + i));
            repeat (3) tick();
            done_in = 1'b1;
            req[ch] = 1'b0;
            tick();
            done_in = 1'b0;
            total_cnt++;
            if (ch_done !== exp || gnt !== 4'b0000 || busy !== 1'b0)
                $display("FAIL rr_done_release%0d: got done %b gnt %b busy %b required %b 0000 0", i, ch_done, gnt, busy, exp);
            else pass_cnt++;
            req[ch] = 1'b1;
        end
        req = '0;
        tick();
        total_cnt++;
        if (done_cnt - d0 != 4) $display("FAIL rr_done_count: got %0d required 4", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_fixed_priority;
        apply_reset();
        fp_req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if (fp_gnt !== 4'b0001) $display("FAIL fp_grant%0d: got %b required 0001", i, fp_gnt);
            else pass_cnt++;
            fp_wen = 4'b0001;
            tick();
            fp_wen = '0;
            repeat (3) tick();
            fp_done_in = 1'b1;
            fp_req[0] = 1'b0;
            tick();
            fp_done_in = 1'b0;
            total_cnt++;
            if (fp_ch_done !== 4'b0001 || fp_gnt !== 4'b0000) $display("FAIL fp_done%0d: got done %b gnt %b required 0001 0000", i, fp_ch_done, fp_gnt);
            else pass_cnt++;
            fp_req[0] = 1'b1;
        end
        fp_req = '0;
        tick();
    endtask

    task automatic test_watchdog;
        int d0;
        apply_reset();
        d0 = done_cnt;
        req = 4'b1010;
        tick();
        total_cnt++;
        if (gnt !== 4'b0010) $display("FAIL wd_grant: got %b required 0010", gnt);
        else pass_cnt++;
        do_write(1, 8'h20, 8'h21);
        repeat (99) tick();
        total_cnt++;
        if (ch_to !== 4'b0000 || gnt !== 4'b0010) $display("FAIL wd_early: got timeout %b gnt %b required 0000 0010", ch_to, gnt);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ch_to !== 4'b0010 || gnt !== 4'b0000 || busy !== 1'b0 || ch_done !== 4'b0000)
            $display("FAIL wd_fire: got timeout %b gnt %b busy %b done %b required 0010 0000 0 0000", ch_to, gnt, busy, ch_done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (gnt !== 4'b1000 || ch_to !== 4'b0000) $display("FAIL wd_next_grant: got gnt %b timeout %b required 1000 0000", gnt, ch_to);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != d0) $display("FAIL wd_no_done: got %0d dones required 0", done_cnt - d0);
        else pass_cnt++;
        req = '0;
        tick();
    endtask

    task automatic test_done_on_timeout;
        int t0;
        apply_reset();
        t0 = to_cnt;
        req = 4'b0010;
        tick();
        do_write(1, 8'h30, 8'h31);
        repeat (99) tick();
        pulse_done();
        total_cnt++;
        if (ch_done !== 4'b0010 || ch_to !== 4'b0000 || gnt !== 4'b0010)
            $display("FAIL tie_done: got done %b timeout %b gnt %b required 0010 0000 0010", ch_done, ch_to, gnt);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (to_cnt != t0) $display("FAIL tie_no_timeout: got %0d timeouts required 0", to_cnt - t0);
        else pass_cnt++;
        req = '0;
        tick();
    endtask

    task automatic test_overrun;
        int w0, o0;
        apply_reset();
        req = 4'b0001;
        tick();
        do_write(0, 8'h3C, 8'h5A);
        tick();
        w0 = wr_cnt; o0 = ovr_cnt;
        wen = 4'b0001; addr[7:0] = 8'hFF; data[7:0] = 8'hFF;
        tick();
        wen = '0;
        total_cnt++;
        if (ovr !== 1'b1) $display("FAIL ovr_owner: got %b required 1", ovr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ovr !== 1'b0) $display("FAIL ovr_width: got %b required 0", ovr);
        else pass_cnt++;
        wen = 4'b0010; addr[15:8] = 8'hEE; data[15:8] = 8'hEE;
        tick();
        wen = '0;
        total_cnt++;
        if (ovr !== 1'b1) $display("FAIL ovr_other: got %b required 1", ovr);
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if (wr_cnt != w0 || ovr_cnt - o0 != 2) $display("FAIL ovr_counts: got writes %0d overruns %0d required 0 2", wr_cnt - w0, ovr_cnt - o0);
        else pass_cnt++;
        total_cnt++;
        if (waddr !== 8'h3C || wdata !== 8'h5A) $display("FAIL ovr_latch: got %h/%h required 3c/5a", waddr, wdata);
        else pass_cnt++;
        pulse_done();
        req = '0;
        tick();
    endtask

    task automatic test_async_reset;
        apply_reset();
        req = 4'b0010;
        tick();
        do_write(1, 8'h01, 8'h02);
        repeat (2) tick();
        pulse_done();
        req = '0;
        tick();
        req = 4'b0100;
        tick();
        total_cnt++;
        if (gnt !== 4'b0100) $display("FAIL ar_pre_grant: got %b required 0100", gnt);
        else pass_cnt++;
        do_write(2, 8'h44, 8'h55);
        #1;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({gnt, ch_done, ch_to, waddr, wdata, wr_o, busy, ovr} !== '0)
            $display("FAIL ar_outputs: got %b required all zero", {gnt, ch_done, ch_to, waddr, wdata, wr_o, busy, ovr});
        else pass_cnt++;
        reset = 1'b1;
        exp_q.delete();
        req = 4'b1010;
        tick();
        total_cnt++;
        if (gnt !== 4'b0010) $display("FAIL ar_rr_restart: got %b required 0010", gnt);
        else pass_cnt++;
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_rr_fairness();
        test_fixed_priority();
        test_watchdog();
        test_done_on_timeout();
        test_overrun();
        test_async_reset();
        repeat (2) tick();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending writes required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
